// File: rtl/band_arb_pkg.sv
// Shared types and constants for the banded run-length arbiter.
// Holds the FSM state encoding and the y -> x band limits.
package band_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int BAND1_LO = 1;
    localparam int BAND1_HI = 3;
    localparam int BAND2_LO = 4;
    localparam int BAND2_HI = 6;
    localparam int BAND3_LO = 7;
    localparam int BAND3_HI = 9;

    // Band index of a count value; 0 means "outside every band, hold x".
    function automatic int band_of(input int v);
        if (v >= BAND1_LO && v <= BAND1_HI) return 1;
        if (v >= BAND2_LO && v <= BAND2_HI) return 2;
        if (v >= BAND3_LO && v <= BAND3_HI) return 3;
        return 0;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin selector: scans upward from ptr with wrap and
// returns the first asserted request as a one-hot grant plus its index.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] grant,
    output logic [IW-1:0]   idx
);

    int   cand;
    logic found;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the loop can leave a value unassigned and infer a latch.
        grant = '0;
        idx   = '0;
        found = 1'b0;
        cand  = 0;
        for (int k = 0; k < NREQ; k++) begin
            cand = (int'(ptr) + k) % NREQ;
            if (!found && req[cand[IW-1:0]]) begin
                grant[cand[IW-1:0]] = 1'b1;
                idx                 = cand[IW-1:0];
                found               = 1'b1;
            end
        end
    end

endmodule

// File: rtl/band_count_arb.sv
// Round-robin arbiter that grants one requester a counted run of len+1
// cycles, publishing the shared count y and its registered band x.
module band_count_arb
    import band_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int CW   = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*CW-1:0]       len,
    output logic [NREQ-1:0]          gnt,
    output logic                     busy,
    output logic [CW-1:0]            y,
    output logic [CW-1:0]            x,
    output logic                     done,
    output logic                     abort,
    output logic [$clog2(NREQ)-1:0]  owner
);

    localparam int IW = $clog2(NREQ);

    state_t          state;
    logic [IW-1:0]   ptr;
    logic [CW-1:0]   len_q;
    logic [NREQ-1:0] arb_gnt;
    logic [IW-1:0]   arb_idx;
    logic [IW-1:0]   ptr_next;
    logic [CW-1:0]   len_arr [NREQ];
    int              y_band;

    for (genvar i = 0; i < NREQ; i++) begin : g_len
        assign len_arr[i] = len[i*CW +: CW];
    end

    rr_arbiter #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_arb (
        .req   (req),
        .ptr   (ptr),
        .grant (arb_gnt),
        .idx   (arb_idx)
    );

    // Priority moves to the requester just after the one being granted.
    assign ptr_next = (int'(arb_idx) == NREQ - 1) ? '0 : arb_idx + 1'b1;
    assign y_band   = band_of(int'(y));

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            gnt   <= '0;
            busy  <= 1'b0;
            y     <= '0;
            x     <= '0;
            done  <= 1'b0;
            abort <= 1'b0;
            owner <= '0;
            ptr   <= '0;
            len_q <= '0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every decision
            // below sees the register values from before this edge.
            done  <= 1'b0;
            abort <= 1'b0;
            case (state)
                IDLE: begin
                    if (|req) begin
                        state <= RUN;
                        gnt   <= arb_gnt;
                        busy  <= 1'b1;
                        y     <= '0;
                        x     <= '0;
                        owner <= arb_idx;
                        ptr   <= ptr_next;
                        len_q <= len_arr[arb_idx];
                    end
                end
                RUN: begin
                    // Completion outranks a dropped request in the same cycle.
                    if (y == len_q) begin
                        done  <= 1'b1;
                        gnt   <= '0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (!req[owner]) begin
                        abort <= 1'b1;
                        gnt   <= '0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        y <= y + 1'b1;
                        if (y_band != 0) x <= CW'(y_band);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_band_count_arb.sv
// Scoreboard bench for band_count_arb: a cycle-level reference model predicts
// every output cycle, a separate monitor compares after each rising edge.
module tb_band_count_arb;

    localparam int NREQ = 4;
    localparam int CW   = 4;
    localparam int IW   = $clog2(NREQ);

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic [NREQ-1:0]     req = '0;
    logic [NREQ*CW-1:0]  len = '0;
    logic [NREQ-1:0]     gnt;
    logic                busy;
    logic [CW-1:0]       y;
    logic [CW-1:0]       x;
    logic                done;
    logic                abort;
    logic [IW-1:0]       owner;

    band_count_arb #(.NREQ(NREQ), .CW(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .len   (len),
        .gnt   (gnt),
        .busy  (busy),
        .y     (y),
        .x     (x),
        .done  (done),
        .abort (abort),
        .owner (owner)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NREQ-1:0] gnt;
        logic            busy;
        logic [CW-1:0]   y;
        logic [CW-1:0]   x;
        logic            done;
        logic            abort;
        logic [IW-1:0]   owner;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Reference model: what the outputs look like in the upcoming cycle.
    bit m_active = 1'b0;
    bit m_done   = 1'b0;
    bit m_abort  = 1'b0;
    int m_owner  = 0;
    int m_len    = 0;
    int m_y      = 0;
    int m_x      = 0;
    int m_next   = 0;

    // x lags y by one cycle and holds outside 1..9, so while counting it is
    // the band of min(y-1, 9), or 0 if y-1 has not yet entered band 1.
    function automatic int band_lagged(input int k);
        int j;
        j = (k - 1 > 9) ? 9 : k - 1;
        return (j < 1) ? 0 : (j + 2) / 3;
    endfunction

    task automatic model_step(input bit rst, input logic [NREQ-1:0] r,
                              input logic [NREQ*CW-1:0] l);
        int i;
        if (rst) begin
            m_active = 0; m_done = 0; m_abort = 0;
            m_owner = 0; m_len = 0; m_y = 0; m_x = 0; m_next = 0;
            return;
        end
        m_done  = 0;
        m_abort = 0;
        if (!m_active) begin
            for (int k = 0; k < NREQ; k++) begin
                i = (m_next + k) % NREQ;
                if (r[i]) begin
                    m_active = 1;
                    m_owner  = i;
                    m_len    = int'(l[i*CW +: CW]);
                    m_y      = 0;
                    m_x      = 0;
                    m_next   = (i + 1) % NREQ;
                    break;
                end
            end
        end else if (m_y == m_len) begin
            m_done   = 1;
            m_active = 0;
        end else if (!r[m_owner]) begin
            m_abort  = 1;
            m_active = 0;
        end else begin
            m_y = m_y + 1;
            m_x = band_lagged(m_y);
        end
    endtask

    // One stimulus cycle: apply inputs, predict the outputs after the edge.
    task automatic drive(input bit rst, input logic [NREQ-1:0] r,
                         input logic [NREQ*CW-1:0] l);
        exp_t e;
        @(negedge clk);
        reset = rst;
        req   = r;
        len   = l;
        model_step(rst, r, l);
        e.gnt   = m_active ? (NREQ'(1) << m_owner) : '0;
        e.busy  = m_active;
        e.y     = CW'(m_y);
        e.x     = CW'(m_x);
        e.done  = m_done;
        e.abort = m_abort;
        e.owner = IW'(m_owner);
        sb_q.push_back(e);
    endtask

    task automatic run_to_end(input logic [NREQ-1:0] r, input logic [NREQ*CW-1:0] l);
        for (int n = 0; n < 40 && !(m_done || m_abort); n++) drive(1'b0, r, l);
    endtask

    // Monitor: independent of stimulus, compares every presented cycle.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                n_checks++;
                if (gnt !== e.gnt || busy !== e.busy || y !== e.y || x !== e.x ||
                    done !== e.done || abort !== e.abort || owner !== e.owner) begin
                    n_errors++;
                    $display("FAIL cycle_outputs t=%0t got gnt=%b busy=%b y=%0d x=%0d done=%b abort=%b owner=%0d want gnt=%b busy=%b y=%0d x=%0d done=%b abort=%b owner=%0d",
                             $time, gnt, busy, y, x, done, abort, owner,
                             e.gnt, e.busy, e.y, e.x, e.done, e.abort, e.owner);
                end
            end
        end
    end

    initial begin
        logic [NREQ-1:0]    rq;
        logic [NREQ*CW-1:0] rl;
        bit                 rr;

        drive(1'b1, '0, '0);
        drive(1'b1, 4'b0001, 16'h0005);

        // Single request, len 5.
        drive(1'b0, 4'b0001, 16'h0005);
        run_to_end(4'b0001, 16'h0005);
        drive(1'b0, '0, 16'h0005);

        // Fairness: all requesting, all len 2, five runs.
        for (int n = 0; n < 5; n++) begin
            drive(1'b0, 4'b1111, 16'h2222);
            run_to_end(4'b1111, 16'h2222);
        end
        drive(1'b0, '0, 16'h2222);

        // Edge lengths: len 0 on requester 1, len 15 on requester 2.
        drive(1'b0, 4'b0010, 16'h0000);
        run_to_end(4'b0010, 16'h0000);
        drive(1'b0, '0, 16'h0000);
        drive(1'b0, 4'b0100, 16'h0F00);
        run_to_end(4'b0100, 16'h0F00);
        drive(1'b0, '0, 16'h0F00);

        // Abort: requester 2 (len 9) drops at y=4 while 3 is waiting.
        drive(1'b0, 4'b0100, 16'h3900);
        for (int n = 0; n < 20 && !(m_active && m_y == 4); n++) drive(1'b0, 4'b1100, 16'h3900);
        drive(1'b0, 4'b1000, 16'h3900);
        drive(1'b0, 4'b1000, 16'h3900);
        run_to_end(4'b1000, 16'h3900);
        drive(1'b0, '0, 16'h3900);

        // Reset at y=6, then 1 and 3 request: pointer restarts at 0.
        drive(1'b0, 4'b0001, 16'h0009);
        for (int n = 0; n < 20 && !(m_active && m_y == 6); n++) drive(1'b0, 4'b0001, 16'h0009);
        drive(1'b1, 4'b0001, 16'h0009);
        drive(1'b0, 4'b1010, 16'h0030);
        run_to_end(4'b1010, 16'h0030);
        drive(1'b0, '0, 16'h0030);

        // Collision: granted req drops in the cycle y == len.
        drive(1'b0, 4'b0001, 16'h0003);
        for (int n = 0; n < 20 && !(m_active && m_y == 3); n++) drive(1'b0, 4'b0001, 16'h0003);
        drive(1'b0, 4'b0000, 16'h0003);
        drive(1'b0, 4'b0000, 16'h0003);

        // Randomized traffic: requests held until granted, occasional aborts,
        // len churning every cycle, rare resets.
        rq = '0;
        rl = '0;
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (m_active && i == m_owner) begin
                    if ($urandom_range(0, 39) == 0) rq[i] = 1'b0;
                end else if (m_done && i == m_owner) begin
                    if ($urandom_range(0, 1) == 0) rq[i] = 1'b0;
                end else if (!rq[i] && $urandom_range(0, 3) == 0) begin
                    rq[i] = 1'b1;
                end
                rl[i*CW +: CW] = CW'($urandom_range(0, 12));
            end
            rr = ($urandom_range(0, 299) == 0);
            drive(rr, rq, rl);
        end

        drive(1'b0, '0, '0);
        drive(1'b0, '0, '0);
        @(posedge clk);
        #3;
        n_checks++;
        if (sb_q.size() != 0) begin
            n_errors++;
            $display("FAIL scoreboard_drain got %0d pending want 0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
